background_gen: RTL
===================

# background_gen

Pixel-colour generator that sits directly downstream of the SPI configuration slave. It consumes the slave's `background_state` and `solid_color` registers, which live in the SCLK domain and are treated here as asynchronous. It brings them into the pixel clock domain, applies them only at frame boundaries to avoid tearing, and produces one registered 6-bit RRGGBB colour per pixel for the VGA output stage.

## Interface
Parameters:
- `RESET_MODE`, 10: active/pending mode after reset; matches the SPI slave's reset value of `background_state`.
- `CHECK_SHIFT`, 5: checkerboard cell size is 2^CHECK_SHIFT pixels.

Ports:
- `clk`  in  1  pixel clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `background_state`  in  8  mode select from the SPI slave; asynchronous to `clk`.
- `solid_color`  in  6  base colour RRGGBB from the SPI slave; asynchronous to `clk`.
- `hpos`  in  10  current pixel column from the VGA timing generator.
- `vpos`  in  10  current pixel row from the VGA timing generator.
- `display_on`  in  1  high inside the visible area.
- `frame_start`  in  1  one-cycle pulse at the first clock of each frame.
- `rgb`  out  6  registered pixel colour, {R[1:0],G[1:0],B[1:0]}.
- `mode_active`  out  8  mode currently being rendered; for debug and test.

## Operation
- Synchronizer: two flops per bit on both input buses (`bs_s1`/`bs_s2`, `sc_s1`/`sc_s2`), followed by a third "previous" register (`bs_d`, `sc_d`).
- Stability filter, per bus:
  - `pending <= s2` only when `s2 == d`, i.e. two consecutive equal samples.
  - Mixed-bit values during skew are therefore never accepted.
- Frame latch: on a `frame_start` cycle, `active_mode <= pending_mode` and `active_color <= pending_color`. Between frames the active values are held regardless of input changes.
- Frame counter `fcnt` (8 bits): increments on each `frame_start`; 255 wraps to 0.
- Pattern, computed from current `hpos`/`vpos` and the active values. All arithmetic is 6-bit modulo with carries discarded.
  - mode 0: `active_color`.
  - mode 1 (vertical bars): `hpos[8:3]`.
  - mode 2 (checkerboard): if `hpos[CHECK_SHIFT]^vpos[CHECK_SHIFT]` then `active_color`, else `~active_color`.
  - mode 3 (scrolling gradient): `vpos[8:3] + fcnt[5:0]`.
  - mode 10 (animated XOR): `(hpos[7:2] ^ vpos[7:2]) + fcnt[7:2]`.
  - any other mode: `6'b000000`.
- Blanking: `rgb <= display_on ? pattern : 0`.
- `mode_active` equals `active_mode`.

## Timing
- Reset values:
  - `rgb` = 0.
  - `mode_active`, `active_mode`, `pending_mode`, and the `bs_*` registers = RESET_MODE.
  - `active_color`, `pending_color`, and the `sc_*` registers = 0.
  - `fcnt` = 0.
- `rst` overrides every other input, including a simultaneous `frame_start`.
- Pixel latency: `rgb` is registered, so it reflects the `hpos`/`vpos`/`display_on` from the previous cycle.
- Config latency: an input bus that is stable before rising edge E1 appears in `pending` after edge E4. It becomes active at the first `frame_start` edge at or after E5.
- `frame_start` cycle:
  - The `rgb` value registered on that edge uses the old `active_*` and old `fcnt`.
  - The new `active_*` and incremented `fcnt` apply from the next edge.
- An input change arriving in the same cycle as `frame_start`: the old `pending` is latched, and the new value waits for the following frame.
- An input that never holds stable for two consecutive `s2` samples leaves `pending` unchanged.
- Back-to-back `frame_start` pulses: each one increments `fcnt` and re-latches `pending`.
- Reset asserted mid-frame: `rgb` goes to 0 on the next edge. The active values return to reset values immediately; they do not wait for a frame boundary.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then `display_on`=1, `hpos`=0x005, `vpos`=0x00A, pulse `frame_start`.
  - Required response: `mode_active`=10; `rgb` = ((1^2)+0) = 6'h03 one cycle after the pixel.
- Solid colour with frame-boundary latching:
  - Stimulus: drive `background_state`=0, `solid_color`=6'h2A mid-frame.
  - Required response: `rgb` holds the mode-10 pattern until the next `frame_start`, then `rgb`=6'h2A. Also check `rgb`=0 whenever `display_on`=0.
- Checkerboard:
  - Stimulus: mode 2, colour 6'h30, `hpos`=32, `vpos`=0.
  - Required response: `rgb`=6'h30. At `hpos`=32, `vpos`=32: `rgb`=6'h0F.
- Scrolling gradient wrap:
  - Stimulus: mode 3, 255 `frame_start` pulses, then one more; `vpos`=8.
  - Required response: `fcnt`=255 gives `rgb` = (1+63) mod 64 = 6'h00; after the wrap `fcnt`=0, `rgb`=6'h01.
- Glitch rejection:
  - Stimulus: toggle `background_state` between 1 and 2 on every clock for 20 cycles, then hold 1.
  - Required response: `pending` updates only after the hold; the next frame gives `mode_active`=1.
- Reset mid-operation:
  - Stimulus: in mode 0 with colour 6'h3F, assert `rst` for 1 cycle mid-line.
  - Required response: `rgb`=0 and `mode_active`=10 on the next edge; the mode-10 pattern resumes without needing a `frame_start`.

Source files
------------

// File: rtl/background_gen.sv
// Pixel colour generator: synchronizes SPI-domain config, filters it for stability,
// applies it only at frame boundaries and renders one registered RRGGBB colour per pixel.
module background_gen #(
   parameter int RESET_MODE  = 10,
   parameter int CHECK_SHIFT = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] background_state,
   input  logic [5:0] solid_color,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       display_on,
   input  logic       frame_start,
   output logic [5:0] rgb,
   output logic [7:0] mode_active
);

   localparam logic [7:0] RST_MODE = 8'(RESET_MODE);

   logic [7:0] bs_s1, bs_s2, bs_d;
   logic [5:0] sc_s1, sc_s2, sc_d;
   logic [7:0] pending_mode, active_mode;
   logic [5:0] pending_color, active_color;
   logic [7:0] fcnt;
   logic [5:0] pattern;
   logic       unused_bits;

   function automatic logic [5:0] render(input logic [7:0] mode, input logic [5:0] color,
                                         input logic [9:0] h, input logic [9:0] v,
                                         input logic [7:0] fc);
      logic [5:0] res;
      case (mode)
         8'd0:    res = color;
         8'd1:    res = h[8:3];
         8'd2:    res = (h[CHECK_SHIFT] ^ v[CHECK_SHIFT]) ? color : ~color;
         8'd3:    res = v[8:3] + fc[5:0];
         8'd10:   res = (h[7:2] ^ v[7:2]) + fc[7:2];
         default: res = 6'b000000;
      endcase
      return res;
   endfunction

   always_comb begin
      pattern = render(active_mode, active_color, hpos, vpos, fcnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bs_s1         <= RST_MODE;
         bs_s2         <= RST_MODE;
         bs_d          <= RST_MODE;
         sc_s1         <= '0;
         sc_s2         <= '0;
         sc_d          <= '0;
         pending_mode  <= RST_MODE;
         pending_color <= '0;
         active_mode   <= RST_MODE;
         active_color  <= '0;
         fcnt          <= '0;
         rgb           <= '0;
      end else begin
         bs_s1 <= background_state;
         bs_s2 <= bs_s1;
         bs_d  <= bs_s2;
         sc_s1 <= solid_color;
         sc_s2 <= sc_s1;
         sc_d  <= sc_s2;
         // accept a value only after two equal synchronized samples, so skewed bits never land
         if (bs_s2 == bs_d) pending_mode <= bs_s2;
         if (sc_s2 == sc_d) pending_color <= sc_s2;
         if (frame_start) begin
            active_mode  <= pending_mode;
            active_color <= pending_color;
            fcnt         <= fcnt + 8'd1;
         end
         rgb <= display_on ? pattern : 6'b000000;
      end
   end

   assign mode_active = active_mode;
   assign unused_bits = ^{hpos[9], hpos[1:0], vpos[9], vpos[1:0]};

endmodule
